// File: rtl/noc_packetizer_if.sv
// AXI-Stream style flit channel shared by the packetizer's payload input and flit output.
interface axis_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4
);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;
   logic [ID_WIDTH-1:0]   tid;
   logic                  tlast;

   // Producer side: drives the flit, listens to back-pressure.
   modport m (
      output tdata,
      output tvalid,
      output tid,
      output tlast,
      input  tready
   );

   // Raw payload consumer: only data and the handshake are meaningful here.
   modport s (
      input  tdata,
      input  tvalid,
      output tready
   );
endinterface

// File: rtl/noc_packetizer.sv
// NoC packetizer: turns a (dest, length) command plus a raw payload stream into
// one routing-header flit followed by exactly 'length' body flits.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | accepting commands; zero-length commands rejected with cmd_err
// HEADER | waiting for the output slot to take the routing header flit
// BODY   | forwarding payload beats, counting down the remaining flits
module noc_packetizer #(
   parameter int DATA_WIDTH     = 32,
   parameter int MAX_ROUTERS_X  = 4,
   parameter int MAX_ROUTERS_Y  = 4,
   parameter int COORD_WIDTH    = $clog2(MAX_ROUTERS_X),
   parameter int SRC_X          = 0,
   parameter int SRC_Y          = 0,
   parameter int ID_WIDTH       = 4,
   parameter int ROUTING_HEADER = 15,
   parameter int BODY_ID        = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [COORD_WIDTH-1:0] cmd_x,
   input  logic [COORD_WIDTH-1:0] cmd_y,
   input  logic [7:0]             cmd_len,
   output logic                   cmd_err,
   axis_if.s                      in,
   axis_if.m                      out
);

   // Header layout needs four coordinates plus the 8-bit length; both mesh
   // dimensions must fit the same coordinate field, and the two TIDs must differ.
   if (DATA_WIDTH < 4*COORD_WIDTH+8 || $clog2(MAX_ROUTERS_Y) != COORD_WIDTH
       || ROUTING_HEADER == BODY_ID) begin : g_bad_params
      $error("noc_packetizer: inconsistent parameters");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HEADER = 2'd1,
      BODY   = 2'd2
   } state_t;

   state_t                 state, state_nxt;
   logic [COORD_WIDTH-1:0] dest_x, dest_y;
   logic [7:0]             len_q;
   logic [7:0]             remaining;

   logic                   o_valid;
   logic [DATA_WIDTH-1:0]  o_data;
   logic [ID_WIDTH-1:0]    o_id;
   logic                   o_last;

   logic                   slot_free;
   logic                   cmd_ready_c;
   logic                   in_ready_c;
   logic                   cmd_take;
   logic                   err_nxt;
   logic                   hdr_load;
   logic                   body_load;
   logic                   last_beat;
   logic [DATA_WIDTH-1:0]  hdr_word;

   // The output register can take a new flit when empty or draining this cycle.
   assign slot_free = !o_valid || out.tready;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode and handshake strobes.
   always_comb begin
      state_nxt   = state;
      cmd_ready_c = 1'b0;
      in_ready_c  = 1'b0;
      cmd_take    = 1'b0;
      err_nxt     = 1'b0;
      hdr_load    = 1'b0;
      body_load   = 1'b0;
      last_beat   = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready_c = 1'b1;
            if (cmd_valid) begin
               if (cmd_len == 8'd0) begin
                  err_nxt = 1'b1;
               end else begin
                  cmd_take  = 1'b1;
                  state_nxt = HEADER;
               end
            end
         end
         HEADER: begin
            if (slot_free) begin
               hdr_load  = 1'b1;
               state_nxt = BODY;
            end
         end
         BODY: begin
            in_ready_c = slot_free;
            if (in.tvalid && slot_free) begin
               body_load = 1'b1;
               if (remaining == 8'd1) begin
                  last_beat = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Routing header: dest y, dest x, source y, source x, length, zero-filled above.
   always_comb begin
      hdr_word = '0;
      hdr_word[COORD_WIDTH-1:0]               = dest_y;
      hdr_word[2*COORD_WIDTH-1:COORD_WIDTH]   = dest_x;
      hdr_word[3*COORD_WIDTH-1:2*COORD_WIDTH] = COORD_WIDTH'(SRC_Y);
      hdr_word[4*COORD_WIDTH-1:3*COORD_WIDTH] = COORD_WIDTH'(SRC_X);
      hdr_word[4*COORD_WIDTH+7:4*COORD_WIDTH] = len_q;
   end

   // Command capture and zero-length reject pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dest_x  <= '0;
         dest_y  <= '0;
         len_q   <= '0;
         cmd_err <= 1'b0;
      end else begin
         cmd_err <= err_nxt;
         if (cmd_take) begin
            dest_x <= cmd_x;
            dest_y <= cmd_y;
            len_q  <= cmd_len;
         end
      end
   end

   // Remaining body-flit counter, armed when the header is loaded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         remaining <= '0;
      end else if (hdr_load) begin
         remaining <= len_q;
      end else if (body_load) begin
         remaining <= remaining - 8'd1;
      end
   end

   // One-entry output register; a reload in the draining cycle keeps it full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_valid <= 1'b0;
         o_data  <= '0;
         o_id    <= '0;
         o_last  <= 1'b0;
      end else if (hdr_load) begin
         o_valid <= 1'b1;
         o_data  <= hdr_word;
         o_id    <= ID_WIDTH'(ROUTING_HEADER);
         o_last  <= 1'b0;
      end else if (body_load) begin
         o_valid <= 1'b1;
         o_data  <= in.tdata;
         o_id    <= ID_WIDTH'(BODY_ID);
         o_last  <= last_beat;
      end else if (out.tready) begin
         o_valid <= 1'b0;
      end
   end

   // cmd_ready stays low while reset is asserted even though the state reads IDLE.
   assign cmd_ready  = cmd_ready_c & rst_n;
   assign in.tready  = in_ready_c;
   assign out.tvalid = o_valid;
   assign out.tdata  = o_data;
   assign out.tid    = o_id;
   assign out.tlast  = o_last;

endmodule

// File: tb/tb_noc_packetizer.sv
// Directed bench for noc_packetizer: header format, throughput, stalls,
// zero-length reject, back-to-back commands, reset abort and payload gaps.
module tb_noc_packetizer;

   localparam int DW  = 32;
   localparam int IW  = 4;
   localparam int HID = 15;
   localparam int BID = 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_x = '0;
   logic [1:0] cmd_y = '0;
   logic [7:0] cmd_len = '0;
   logic       cmd_err;

   axis_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW)) in_if ();
   axis_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW)) out_if ();

   noc_packetizer #(
      .DATA_WIDTH(DW), .MAX_ROUTERS_X(4), .MAX_ROUTERS_Y(4), .COORD_WIDTH(2),
      .SRC_X(0), .SRC_Y(3), .ID_WIDTH(IW), .ROUTING_HEADER(HID), .BODY_ID(BID)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_len(cmd_len), .cmd_err(cmd_err),
      .in(in_if.s), .out(out_if.m)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  id;
      logic        l;
   } flit_t;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] pay [4];
   int          pay_idx = 0;
   int          pay_n = 0;
   logic        pay_en = 1'b0;
   logic        held = 1'b0;
   logic [31:0] held_d;
   logic [3:0]  held_id;
   logic        held_l;
   flit_t       cap [$];
   logic [31:0] exp_d [4];
   logic [3:0]  exp_id [4];
   logic        exp_l [4];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_flit(input string tag, input logic [31:0] d, input logic [3:0] id,
                           input logic l);
      chk({tag, "_valid"}, 32'(out_if.tvalid), 32'd1);
      chk({tag, "_data"}, out_if.tdata, d);
      chk({tag, "_tid"}, 32'(out_if.tid), 32'(id));
      chk({tag, "_tlast"}, 32'(out_if.tlast), 32'(l));
   endtask

   task automatic drive_pay();
      in_if.tvalid = pay_en && (pay_idx < pay_n);
      in_if.tdata  = (pay_idx < pay_n) ? pay[pay_idx] : 32'h0;
   endtask

   task automatic load_pay(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      pay[0] = a; pay[1] = b; pay[2] = c; pay[3] = 32'h0;
      pay_idx = 0;
      pay_n = 3;
      pay_en = 1'b1;
      drive_pay();
   endtask

   // Observe handshakes just before the edge, then move to 1 time unit after it.
   task automatic step();
      logic in_hs;
      @(negedge clk);
      in_hs = in_if.tvalid && in_if.tready;
      if (held) begin
         chk("hold_valid", 32'(out_if.tvalid), 32'd1);
         chk("hold_data", out_if.tdata, held_d);
         chk("hold_tid", 32'(out_if.tid), 32'(held_id));
         chk("hold_tlast", 32'(out_if.tlast), 32'(held_l));
      end
      held    = out_if.tvalid && !out_if.tready;
      held_d  = out_if.tdata;
      held_id = out_if.tid;
      held_l  = out_if.tlast;
      if (out_if.tvalid && out_if.tready) begin
         cap.push_back({out_if.tdata, out_if.tid, out_if.tlast});
      end
      @(posedge clk);
      #1;
      if (in_hs) pay_idx++;
      drive_pay();
   endtask

   task automatic send_cmd(input logic [1:0] x, input logic [1:0] y, input logic [7:0] len);
      cmd_x = x; cmd_y = y; cmd_len = len; cmd_valid = 1'b1;
   endtask

   initial begin
      in_if.tvalid  = 1'b0;
      in_if.tdata   = '0;
      in_if.tid     = '0;
      in_if.tlast   = 1'b0;
      out_if.tready = 1'b1;

      // Reset values
      #2 rst_n = 1'b0;
      #1;
      chk("rst_tvalid", 32'(out_if.tvalid), 32'd0);
      chk("rst_tdata", out_if.tdata, 32'd0);
      chk("rst_tid", 32'(out_if.tid), 32'd0);
      chk("rst_tlast", 32'(out_if.tlast), 32'd0);
      chk("rst_cmd_err", 32'(cmd_err), 32'd0);
      chk("rst_in_ready", 32'(in_if.tready), 32'd0);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      step();
      step();
      #2 rst_n = 1'b1;
      step();
      chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

      // Basic packet, full throughput: header 0x339 then A, B, C
      load_pay(32'hA, 32'hB, 32'hC);
      send_cmd(2'd2, 2'd1, 8'd3);
      step();
      cmd_valid = 1'b0;
      chk("t1_hdr_state_tvalid", 32'(out_if.tvalid), 32'd0);
      chk("t1_hdr_in_ready", 32'(in_if.tready), 32'd0);
      chk("t1_hdr_cmd_ready", 32'(cmd_ready), 32'd0);
      step();
      chk_flit("t1_header", 32'h339, 4'(HID), 1'b0);
      step();
      chk_flit("t1_body0", 32'hA, 4'(BID), 1'b0);
      step();
      chk_flit("t1_body1", 32'hB, 4'(BID), 1'b0);
      step();
      chk_flit("t1_body2", 32'hC, 4'(BID), 1'b1);
      chk("t1_end_in_ready", 32'(in_if.tready), 32'd0);
      chk("t1_end_cmd_ready", 32'(cmd_ready), 32'd1);
      step();
      chk("t1_drain_tvalid", 32'(out_if.tvalid), 32'd0);
      chk("t1_consumed", 32'(pay_idx), 32'd3);

      // Zero-length command is rejected with a one-cycle error pulse
      send_cmd(2'd1, 2'd1, 8'd0);
      step();
      cmd_valid = 1'b0;
      chk("t2_err_pulse", 32'(cmd_err), 32'd1);
      chk("t2_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("t2_tvalid", 32'(out_if.tvalid), 32'd0);
      step();
      chk("t2_err_clear", 32'(cmd_err), 32'd0);
      chk("t2_tvalid_after", 32'(out_if.tvalid), 32'd0);
      chk("t2_cmd_ready_after", 32'(cmd_ready), 32'd1);

      // Same packet with out.TREADY low every other cycle
      exp_d[0] = 32'h339; exp_id[0] = 4'(HID); exp_l[0] = 1'b0;
      exp_d[1] = 32'h11;  exp_id[1] = 4'(BID); exp_l[1] = 1'b0;
      exp_d[2] = 32'h22;  exp_id[2] = 4'(BID); exp_l[2] = 1'b0;
      exp_d[3] = 32'h33;  exp_id[3] = 4'(BID); exp_l[3] = 1'b1;
      cap.delete();
      load_pay(32'h11, 32'h22, 32'h33);
      send_cmd(2'd2, 2'd1, 8'd3);
      step();
      cmd_valid = 1'b0;
      for (int i = 0; i < 40 && cap.size() < 4; i++) begin
         out_if.tready = (i % 2) == 1;
         step();
      end
      out_if.tready = 1'b1;
      step();
      chk("t3_flit_count", 32'(cap.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < cap.size()) begin
            chk("t3_data", cap[i].d, exp_d[i]);
            chk("t3_tid", 32'(cap[i].id), 32'(exp_id[i]));
            chk("t3_tlast", 32'(cap[i].l), 32'(exp_l[i]));
         end
      end
      chk("t3_consumed", 32'(pay_idx), 32'd3);
      chk("t3_idle_tvalid", 32'(out_if.tvalid), 32'd0);

      // Back-to-back commands: len=1 (hdr 0x136) then len=2 (hdr 0x23C)
      load_pay(32'h51, 32'h61, 32'h62);
      send_cmd(2'd1, 2'd2, 8'd1);
      step();
      send_cmd(2'd3, 2'd0, 8'd2);
      chk("t4_busy_cmd_ready", 32'(cmd_ready), 32'd0);
      step();
      chk_flit("t4_hdr1", 32'h136, 4'(HID), 1'b0);
      step();
      chk_flit("t4_body1", 32'h51, 4'(BID), 1'b1);
      chk("t4_accept_ready", 32'(cmd_ready), 32'd1);
      step();
      cmd_valid = 1'b0;
      chk("t4_gap_tvalid", 32'(out_if.tvalid), 32'd0);
      chk("t4_hdr2_cmd_ready", 32'(cmd_ready), 32'd0);
      step();
      chk_flit("t4_hdr2", 32'h23C, 4'(HID), 1'b0);
      step();
      chk_flit("t4_body2a", 32'h61, 4'(BID), 1'b0);
      step();
      chk_flit("t4_body2b", 32'h62, 4'(BID), 1'b1);
      step();
      chk("t4_drain_tvalid", 32'(out_if.tvalid), 32'd0);

      // Reset after header plus one body flit of a 3-flit packet
      load_pay(32'h71, 32'h72, 32'h73);
      send_cmd(2'd2, 2'd1, 8'd3);
      step();
      cmd_valid = 1'b0;
      step();
      chk_flit("t5_header", 32'h339, 4'(HID), 1'b0);
      step();
      chk_flit("t5_body0", 32'h71, 4'(BID), 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rst_tvalid", 32'(out_if.tvalid), 32'd0);
      chk("t5_rst_tlast", 32'(out_if.tlast), 32'd0);
      chk("t5_rst_in_ready", 32'(in_if.tready), 32'd0);
      step();
      #2 rst_n = 1'b1;
      step();
      chk("t5_post_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("t5_post_tvalid", 32'(out_if.tvalid), 32'd0);
      chk("t5_post_in_ready", 32'(in_if.tready), 32'd0);
      chk("t5_untouched", 32'(pay_idx), 32'd1);
      send_cmd(2'd3, 2'd3, 8'd1);
      step();
      cmd_valid = 1'b0;
      step();
      chk_flit("t5_new_header", 32'h13F, 4'(HID), 1'b0);
      step();
      chk_flit("t5_new_body", 32'h72, 4'(BID), 1'b1);
      step();
      chk("t5_drain_tvalid", 32'(out_if.tvalid), 32'd0);
      chk("t5_consumed", 32'(pay_idx), 32'd2);

      // Payload gap of 5 cycles in the middle of a packet (hdr 0x332)
      load_pay(32'h81, 32'h82, 32'h83);
      send_cmd(2'd0, 2'd2, 8'd3);
      step();
      cmd_valid = 1'b0;
      step();
      chk_flit("t6_header", 32'h332, 4'(HID), 1'b0);
      step();
      chk_flit("t6_body0", 32'h81, 4'(BID), 1'b0);
      pay_en = 1'b0;
      drive_pay();
      step();
      chk("t6_gap_tvalid", 32'(out_if.tvalid), 32'd0);
      chk("t6_gap_in_ready", 32'(in_if.tready), 32'd1);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t6_gap_hold", 32'(out_if.tvalid), 32'd0);
      end
      pay_en = 1'b1;
      drive_pay();
      step();
      chk_flit("t6_body1", 32'h82, 4'(BID), 1'b0);
      step();
      chk_flit("t6_body2", 32'h83, 4'(BID), 1'b1);
      step();
      chk("t6_drain_tvalid", 32'(out_if.tvalid), 32'd0);
      chk("t6_consumed", 32'(pay_idx), 32'd3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
